// File: rtl/risc_dmem_responder_pkg.sv
// risc_dmem_responder_pkg: FSM state encodings, log2 helper and default widths shared by the responder and its benches
package risc_dmem_responder_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic int log2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/risc_dmem_array.sv
// risc_dmem_array: DEPTH x DATA_W storage with byte-enabled synchronous write and registered read, no reset
module risc_dmem_array #(
    parameter int DATA_W = 32,
    parameter int IW     = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IW-1:0]       widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [IW-1:0]       ridx,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [2**IW];

    // write only the enabled byte lanes
    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < DATA_W / 8; i++)
                if (be[i]) mem[widx][i*8+:8] <= wdata[i*8+:8];

    // read port registered every cycle
    always_ff @(posedge clk)
        rdata <= mem[ridx];

endmodule

// File: rtl/risc_dmem_responder.sv
// risc_dmem_responder: wait-state data-memory slave; RISC_DMEM_ADDR_CHECK_EN flags out-of-range accesses
module risc_dmem_responder
    import risc_dmem_responder_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int NB = DATA_W / 8;
    localparam int LB = log2(NB);
    localparam int IW = log2(DEPTH_WORDS);

    state_t            state, state_d;
    logic [3:0]        cnt;
    logic              acc, fire, done, oor_now;
    logic              cap_we, cap_oor;
    logic [IW-1:0]     cap_idx, ridx;
    logic [DATA_W-1:0] cap_wdata, arr_rd;
    logic [NB-1:0]     cap_be;
    logic              unused_addr;

    assign unused_addr = ^req_addr;

`ifdef RISC_DMEM_ADDR_CHECK_EN
    assign oor_now = {1'b0, req_addr} >= (ADDR_W+1)'(DEPTH_WORDS * NB);
`else
    assign oor_now = 1'b0;
`endif

    // handshake decode, next state, and read address (live request in IDLE so data is ready by the response edge)
    always_comb begin
        acc     = state == S_IDLE && req_valid && req_ready;
        fire    = state == S_BUSY && cnt == 4'd0;
        done    = state == S_RESP && rsp_ready;
        state_d = acc ? S_BUSY : fire ? S_RESP : done ? S_IDLE : state;
        ridx    = state == S_IDLE ? req_addr[LB+:IW] : cap_idx;
    end

    // state register
    always_ff @(posedge clk)
        if (!reset) state <= S_IDLE;
        else state <= state_d;

    // registered outputs and wait counter
    always_ff @(posedge clk)
        if (!reset) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            req_ready <= state_d == S_IDLE;
            rsp_valid <= state_d == S_RESP;
            cnt       <= acc ? 4'(WAIT_CYCLES) : (state == S_BUSY && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            if (fire) begin
                rsp_rdata <= (cap_we || cap_oor) ? '0 : arr_rd;
                rsp_err   <= cap_oor;
            end else if (done) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end

    // request capture at the acceptance edge
    always_ff @(posedge clk)
        if (acc) begin
            cap_we    <= req_we;
            cap_idx   <= req_addr[LB+:IW];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            cap_oor   <= oor_now;
        end

    risc_dmem_array #(.DATA_W(DATA_W), .IW(IW)) u_array (
        .clk  (clk),
        .we   (fire && cap_we && !cap_oor),
        .be   (cap_be),
        .widx (cap_idx),
        .wdata(cap_wdata),
        .ridx (ridx),
        .rdata(arr_rd)
    );

endmodule

// File: tb/tb_risc_dmem_responder.sv
// tb_risc_dmem_responder: directed vector table plus reset/backpressure sequences on WAIT=2 and WAIT=0 instances
module tb_risc_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0, req_we = '0, rsp_ready = '0;
    logic [1:0]  req_ready, rsp_valid, rsp_err;
    logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2];
    logic [3:0]  req_be[2];
    int          total = 0, bad = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    vec_t v[$];

    always #5 clk = ~clk;

    risc_dmem_responder #(.WAIT_CYCLES(2)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    risc_dmem_responder #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int s, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic r;
        bit   ok = 0;
        req_we[s] = we; req_addr[s] = a; req_wdata[s] = d; req_be[s] = be; req_valid[s] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            r = req_ready[s];
            tick();
            ok = r;
        end
        req_valid[s] = 1'b0; req_we[s] = ~we; req_addr[s] = ~a; req_wdata[s] = ~d; req_be[s] = ~be;
        if (!ok) chk("accept timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input int s, input string n, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] er, input logic ee, input int el);
        int lat = 0;
        issue(s, we, a, d, be);
        while (!rsp_valid[s] && lat < 40) begin
            tick();
            lat++;
        end
        chk({n, " latency"}, 32'(lat), 32'(el));
        chk({n, " rdata"}, rsp_rdata[s], er);
        chk({n, " err"}, {31'b0, rsp_err[s]}, {31'b0, ee});
        rsp_ready[s] = 1'b1;
        tick();
        rsp_ready[s] = 1'b0;
        chk({n, " valid drop"}, {31'b0, rsp_valid[s]}, 32'd0);
        chk({n, " ready back"}, {31'b0, req_ready[s]}, 32'd1);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_addr[s] = '0; req_wdata[s] = '0; req_be[s] = '0;
        end
        v.push_back('{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
        v.push_back('{1'b1, 32'h010, 32'h11223344, 4'b0101, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h010, 32'h0, 4'h0, 32'hDE22BE44, 1'b0});
        v.push_back('{1'b1, 32'h010, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h010, 32'h0, 4'h0, 32'hDE22BE44, 1'b0});
        v.push_back('{1'b0, 32'h013, 32'h0, 4'h0, 32'hDE22BE44, 1'b0});
        v.push_back('{1'b1, 32'h000, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0});
`ifdef RISC_DMEM_ADDR_CHECK_EN
        v.push_back('{1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1});
        v.push_back('{1'b1, 32'h400, 32'h0BADBAD0, 4'hF, 32'h0, 1'b1});
        v.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0});
`else
        v.push_back('{1'b0, 32'h400, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0});
        v.push_back('{1'b1, 32'h400, 32'h0BADBAD0, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'h0BADBAD0, 1'b0});
`endif
        v.push_back('{1'b1, 32'h020, 32'h13579BDF, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b1, 32'h040, 32'h12345678, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b1, 32'h040, 32'hAB000000, 4'b1000, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h040, 32'h0, 4'h0, 32'hAB345678, 1'b0});

        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h10; req_wdata[1] = 32'h0BAD0BAD; req_be[1] = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset%0d ready", i), {31'b0, req_ready[1]}, 32'd0);
            chk($sformatf("reset%0d valid", i), {31'b0, rsp_valid[1]}, 32'd0);
        end
        chk("reset rdata", rsp_rdata[1], 32'd0);
        chk("reset err", {31'b0, rsp_err[1]}, 32'd0);
        req_valid[1] = 1'b0;
        reset = 1'b1;
        tick();
        chk("ready after reset", {31'b0, req_ready[1]}, 32'd1);

        foreach (v[i]) txn(1, $sformatf("vec%0d", i), v[i].we, v[i].a, v[i].d, v[i].be, v[i].er, v[i].ee, 3);

        issue(1, 1'b0, 32'h010, 32'h0, 4'h0);
        for (int i = 0; i < 10 && !rsp_valid[1]; i++) tick();
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h010; req_wdata[1] = 32'h0; req_be[1] = 4'hF;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d valid", i), {31'b0, rsp_valid[1]}, 32'd1);
            chk($sformatf("bp%0d rdata", i), rsp_rdata[1], 32'hDE22BE44);
            chk($sformatf("bp%0d ready", i), {31'b0, req_ready[1]}, 32'd0);
            tick();
        end
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b0;
        chk("bp valid drop", {31'b0, rsp_valid[1]}, 32'd0);
        chk("bp ready back", {31'b0, req_ready[1]}, 32'd1);
        txn(1, "bp no write", 1'b0, 32'h010, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 3);

        issue(1, 1'b1, 32'h020, 32'hFFFF0000, 4'hF);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("busy reset valid", {31'b0, rsp_valid[1]}, 32'd0);
        chk("busy reset ready", {31'b0, req_ready[1]}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("busy reset no rsp", {31'b0, rsp_valid[1]}, 32'd0);
        txn(1, "busy reset old", 1'b0, 32'h020, 32'h0, 4'h0, 32'h13579BDF, 1'b0, 3);

        reset = 1'b0;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h040; req_wdata[1] = 32'hFFFFFFFF; req_be[1] = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        req_valid[1] = 1'b0;
        reset = 1'b1;
        tick();
        txn(1, "reset no write", 1'b0, 32'h040, 32'h0, 4'h0, 32'hAB345678, 1'b0, 3);

        issue(1, 1'b1, 32'h040, 32'h00000000, 4'hF);
        for (int i = 0; i < 10 && !rsp_valid[1]; i++) tick();
        chk("resp reached", {31'b0, rsp_valid[1]}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("resp reset valid", {31'b0, rsp_valid[1]}, 32'd0);
        txn(1, "resp reset wrote", 1'b0, 32'h040, 32'h0, 4'h0, 32'h0, 1'b0, 3);

        txn(0, "w0 write", 1'b1, 32'h008, 32'h01020304, 4'hF, 32'h0, 1'b0, 1);
        txn(0, "w0 read", 1'b0, 32'h008, 32'h0, 4'h0, 32'h01020304, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
